intr_pc_ctrl: RTL and testbench

//  Program-counter and return-address controller of the single-cycle CPU.

---
 rtl/intr_pc_ctrl.sv | 162 ++++++++++++++++
 tb/tb_intr_pc_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_pc_ctrl.sv
// intr_pc_ctrl: next-PC select, return-address LIFO and ISR entry/exit tracking.
// Optional INTR_MASK_EN adds ei/di inputs and the ie_o interrupt-enable output.
module intr_pc_ctrl #(
   parameter int            AW       = 10,
   parameter int            DEPTH    = 8,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] pc_seq,
   input  logic [AW-1:0] pc_tgt,
   input  logic          jump,
   input  logic          call,
   input  logic          ret,
   input  logic          reti,
   input  logic          s_interrup,
   input  logic [AW-1:0] dir,
`ifdef INTR_MASK_EN
   input  logic          ei,
   input  logic          di,
   output logic          ie_o,
`endif
   output logic [AW-1:0] pc,
   output logic          fin,
   output logic          in_isr,
   output logic          stk_ovf,
   output logic          stk_unf
);

   localparam int             SPW     = $clog2(DEPTH + 1);
   localparam int             IW      = $clog2(DEPTH);
   localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

   logic [AW-1:0]  pc_q, pc_d;
   logic [AW-1:0]  vec_q, vec_d;
   logic [SPW-1:0] sp_q, sp_d;
   logic           in_isr_q, in_isr_d;
   logic           fin_q, fin_d;
   logic           pend_q, pend_d;
   logic           ovf_q, ovf_d;
   logic           unf_q, unf_d;
   logic [AW-1:0]  stack_q [DEPTH];

   logic           pop;
   logic           take_int;
   logic           push_en;
   logic [AW-1:0]  push_data;
   logic [AW-1:0]  nx;
   logic           ie_en;

   assign pop      = ret | reti;
   assign take_int = pend_q & ~call & ~pop;
   assign nx       = (call | jump) ? pc_tgt : pc_seq;

   // NOTE: every signal gets a default before any branch so no latch is inferred.
   always_comb begin
      pc_d      = pc_q;
      vec_d     = vec_q;
      sp_d      = sp_q;
      in_isr_d  = in_isr_q;
      fin_d     = 1'b0;
      pend_d    = pend_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      push_en   = 1'b0;
      push_data = '0;

      if (s_interrup && !pend_q && !in_isr_q && ie_en) begin
         pend_d = 1'b1;
         vec_d  = dir;
      end

      if (pop) begin
         if (sp_q == '0) begin
            pc_d  = pc_seq;
            unf_d = 1'b1;
         end else begin
            pc_d = stack_q[IW'(sp_q - SPW'(1))];
            sp_d = sp_q - SPW'(1);
         end
         if (reti && in_isr_q) begin
            in_isr_d = 1'b0;
            fin_d    = 1'b1;
         end
      end else if (take_int) begin
         push_en   = 1'b1;
         push_data = nx;
         pc_d      = vec_q;
         pend_d    = 1'b0;
         in_isr_d  = 1'b1;
      end else if (call) begin
         push_en   = 1'b1;
         push_data = pc_seq;
         pc_d      = pc_tgt;
      end else begin
         pc_d = nx;
      end

      // A push onto a full stack is dropped; the PC still moves.
      if (push_en) begin
         if (sp_q == SP_FULL) ovf_d = 1'b1;
         else                 sp_d  = sp_q + SPW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         vec_q    <= '0;
         sp_q     <= '0;
         in_isr_q <= 1'b0;
         fin_q    <= 1'b0;
         pend_q   <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         vec_q    <= vec_d;
         sp_q     <= sp_d;
         in_isr_q <= in_isr_d;
         fin_q    <= fin_d;
         pend_q   <= pend_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // NOTE: stack storage is deliberately not reset; sp_q alone says which entries are live.
   always_ff @(posedge clk) begin
      if (!reset && push_en && sp_q != SP_FULL)
         stack_q[IW'(sp_q)] <= push_data;
   end

`ifdef INTR_MASK_EN
   logic ie_q, ie_d;

   always_comb begin
      ie_d = ie_q;
      if (ei)       ie_d = 1'b1;
      if (di)       ie_d = 1'b0;
      if (take_int) ie_d = 1'b0;
      if (reti)     ie_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) ie_q <= 1'b0;
      else       ie_q <= ie_d;
   end

   assign ie_en = ie_q;
   assign ie_o  = ie_q;
`else
   assign ie_en = 1'b1;
`endif

   assign pc      = pc_q;
   assign fin     = fin_q;
   assign in_isr  = in_isr_q;
   assign stk_ovf = ovf_q;
   assign stk_unf = unf_q;

endmodule

// File: tb/tb_intr_pc_ctrl.sv
// Scoreboard bench for intr_pc_ctrl: a queue-based reference model predicts each cycle's outputs.
// Build with +define+INTR_MASK_EN to also exercise the interrupt-enable mask.
module tb_intr_pc_ctrl;

   localparam int AW    = 10;
   localparam int DEPTH = 8;

   typedef struct packed {
      logic          rst, jump, call, ret, reti, intr, ei, di;
      logic [AW-1:0] tgt, dir;
   } ctrl_t;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic          fin, in_isr, ovf, unf, ie;
   } obs_t;

   logic          clk = 1'b0;
   logic          reset, jump, call, ret, reti, s_interrup;
   logic [AW-1:0] pc_seq, pc_tgt, dir;
   logic [AW-1:0] pc;
   logic          fin, in_isr, stk_ovf, stk_unf;
`ifdef INTR_MASK_EN
   logic          ei, di, ie_o;
   localparam logic IE_RST = 1'b0;
`else
   localparam logic IE_RST = 1'b1;
`endif

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [AW-1:0] m_pc  = '0;
   logic [AW-1:0] m_vec = '0;
   logic [AW-1:0] m_stk [$];
   logic          m_fin = 0, m_isr = 0, m_pend = 0, m_ovf = 0, m_unf = 0, m_ie = IE_RST;

   obs_t  sb_q [$];
   ctrl_t st_q [$];
   int    xp_q [$];

   always #5 clk = ~clk;

   intr_pc_ctrl #(.AW(AW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
      .clk        (clk),
      .reset      (reset),
      .pc_seq     (pc_seq),
      .pc_tgt     (pc_tgt),
      .jump       (jump),
      .call       (call),
      .ret        (ret),
      .reti       (reti),
      .s_interrup (s_interrup),
      .dir        (dir),
`ifdef INTR_MASK_EN
      .ei         (ei),
      .di         (di),
      .ie_o       (ie_o),
`endif
      .pc         (pc),
      .fin        (fin),
      .in_isr     (in_isr),
      .stk_ovf    (stk_ovf),
      .stk_unf    (stk_unf)
   );

   function automatic ctrl_t ctl(input logic rst, input logic jmp, input logic cl,
                                 input logic rt, input logic rti, input logic irq,
                                 input logic [AW-1:0] tgt, input logic [AW-1:0] vec);
      ctrl_t c;
      c.rst = rst; c.jump = jmp; c.call = cl; c.ret = rt; c.reti = rti; c.intr = irq;
      c.ei = 1'b1; c.di = 1'b0; c.tgt = tgt; c.dir = vec;
      return c;
   endfunction

   function automatic ctrl_t idle();
      return ctl(0, 0, 0, 0, 0, 0, '0, '0);
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.pc = pc; o.fin = fin; o.in_isr = in_isr; o.ovf = stk_ovf; o.unf = stk_unf;
`ifdef INTR_MASK_EN
      o.ie = ie_o;
`else
      o.ie = 1'b1;
`endif
      return o;
   endfunction

   task automatic add(input ctrl_t c, input int p);
      st_q.push_back(c);
      xp_q.push_back(p);
   endtask

   // Drives one cycle, advances the model, queues the prediction, returns 1 ns after the edge.
   task automatic drive_cycle(input ctrl_t c);
      obs_t          e;
      logic [AW-1:0] seq, nx, pushv;
      logic          do_push, o_pend, o_isr, o_ie;
      seq = m_pc + 1'b1;
      reset = c.rst; jump = c.jump; call = c.call; ret = c.ret; reti = c.reti;
      s_interrup = c.intr; pc_tgt = c.tgt; dir = c.dir; pc_seq = seq;
`ifdef INTR_MASK_EN
      ei = c.ei; di = c.di;
`endif
      if (c.rst) begin
         m_pc = '0; m_stk.delete(); m_fin = 0; m_isr = 0; m_pend = 0;
         m_ovf = 0; m_unf = 0; m_ie = IE_RST;
      end else begin
         o_pend = m_pend; o_isr = m_isr; o_ie = m_ie;
         do_push = 0; pushv = '0; m_fin = 0;
         nx = (c.call || c.jump) ? c.tgt : seq;
         if (c.intr && !o_pend && !o_isr && o_ie) begin
            m_pend = 1; m_vec = c.dir;
         end
`ifdef INTR_MASK_EN
         if (c.ei) m_ie = 1;
         if (c.di) m_ie = 0;
`endif
         if (c.ret || c.reti) begin
            if (m_stk.size() == 0) begin m_pc = seq; m_unf = 1; end
            else m_pc = m_stk.pop_back();
            if (c.reti && o_isr) begin m_isr = 0; m_fin = 1; end
`ifdef INTR_MASK_EN
            if (c.reti) m_ie = 1;
`endif
         end else if (o_pend && !c.call) begin
            do_push = 1; pushv = nx; m_pc = m_vec; m_pend = 0; m_isr = 1;
`ifdef INTR_MASK_EN
            m_ie = 0;
`endif
         end else if (c.call) begin
            do_push = 1; pushv = seq; m_pc = c.tgt;
         end else begin
            m_pc = nx;
         end
         if (do_push) begin
            if (m_stk.size() >= DEPTH) m_ovf = 1;
            else m_stk.push_back(pushv);
         end
      end
      e.pc = m_pc; e.fin = m_fin; e.in_isr = m_isr; e.ovf = m_ovf; e.unf = m_unf; e.ie = m_ie;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t got, exp;
      int   p, n = 0;
      add(ctl(1, 0, 0, 0, 0, 0, '0, '0), 0);
      add(ctl(1, 0, 0, 0, 0, 1, 10'd7, 10'd9), 0);
      while (st_q.size() != 0) begin
         drive_cycle(st_q.pop_front());
         exp = sb_q.pop_front(); got = observe(); p = xp_q.pop_front(); n++;
         checks++;
         if (got !== exp) begin errors++; $display("FAIL reset step %0d: got %p expected %p", n, got, exp); end
         if (p >= 0) begin
            checks++;
            if (got.pc !== AW'(p)) begin errors++; $display("FAIL reset pc step %0d: got %0d expected %0d", n, got.pc, p); end
         end
      end
   endtask

   task automatic test_seq();
      obs_t got, exp;
      int   p, n = 0;
      for (int i = 1; i <= 5; i++) add(idle(), i);
      while (st_q.size() != 0) begin
         drive_cycle(st_q.pop_front());
         exp = sb_q.pop_front(); got = observe(); p = xp_q.pop_front(); n++;
         checks++;
         if (got !== exp) begin errors++; $display("FAIL seq step %0d: got %p expected %p", n, got, exp); end
         if (p >= 0) begin
            checks++;
            if (got.pc !== AW'(p)) begin errors++; $display("FAIL seq pc step %0d: got %0d expected %0d", n, got.pc, p); end
         end
      end
   endtask

   task automatic test_call_ret();
      obs_t got, exp;
      int   p, n = 0;
      add(ctl(0, 0, 1, 0, 0, 0, 10'd40, '0), 40);
      add(ctl(0, 0, 0, 1, 0, 0, '0, '0), 6);
      while (st_q.size() != 0) begin
         drive_cycle(st_q.pop_front());
         exp = sb_q.pop_front(); got = observe(); p = xp_q.pop_front(); n++;
         checks++;
         if (got !== exp) begin errors++; $display("FAIL call_ret step %0d: got %p expected %p", n, got, exp); end
         if (p >= 0) begin
            checks++;
            if (got.pc !== AW'(p)) begin errors++; $display("FAIL call_ret pc step %0d: got %0d expected %0d", n, got.pc, p); end
         end
      end
   endtask

   task automatic test_interrupt();
      obs_t got, exp;
      int   p, n = 0;
      for (int i = 7; i <= 10; i++) add(idle(), i);
      add(ctl(0, 0, 0, 0, 0, 1, '0, 10'd984), 11);
      add(idle(), 984);
      add(idle(), 985);
      add(ctl(0, 0, 0, 0, 1, 0, '0, '0), 12);
      add(idle(), 13);
      while (st_q.size() != 0) begin
         drive_cycle(st_q.pop_front());
         exp = sb_q.pop_front(); got = observe(); p = xp_q.pop_front(); n++;
         checks++;
         if (got !== exp) begin errors++; $display("FAIL interrupt step %0d: got %p expected %p", n, got, exp); end
         if (p >= 0) begin
            checks++;
            if (got.pc !== AW'(p)) begin errors++; $display("FAIL interrupt pc step %0d: got %0d expected %0d", n, got.pc, p); end
         end
      end
   endtask

   task automatic test_defer();
      obs_t got, exp;
      int   p, n = 0;
      add(ctl(0, 0, 0, 0, 0, 1, '0, 10'd700), 14);
      add(ctl(0, 0, 1, 0, 0, 0, 10'd50, '0), 50);
      add(idle(), 700);
      add(ctl(0, 0, 0, 0, 0, 1, '0, 10'd300), 701);
      add(idle(), 702);
      add(ctl(0, 0, 0, 0, 1, 0, '0, '0), 51);
      add(ctl(0, 0, 0, 1, 0, 0, '0, '0), 15);
      add(idle(), 16);
      while (st_q.size() != 0) begin
         drive_cycle(st_q.pop_front());
         exp = sb_q.pop_front(); got = observe(); p = xp_q.pop_front(); n++;
         checks++;
         if (got !== exp) begin errors++; $display("FAIL defer step %0d: got %p expected %p", n, got, exp); end
         if (p >= 0) begin
            checks++;
            if (got.pc !== AW'(p)) begin errors++; $display("FAIL defer pc step %0d: got %0d expected %0d", n, got.pc, p); end
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_t got, exp;
      int   p, n = 0;
      add(ctl(0, 1, 0, 0, 0, 0, 10'd200, '0), 200);
      add(ctl(0, 1, 1, 0, 0, 0, 10'd300, '0), 300);
      add(ctl(0, 0, 1, 1, 0, 0, 10'd400, '0), 201);
      add(idle(), 202);
      while (st_q.size() != 0) begin
         drive_cycle(st_q.pop_front());
         exp = sb_q.pop_front(); got = observe(); p = xp_q.pop_front(); n++;
         checks++;
         if (got !== exp) begin errors++; $display("FAIL back_to_back step %0d: got %p expected %p", n, got, exp); end
         if (p >= 0) begin
            checks++;
            if (got.pc !== AW'(p)) begin errors++; $display("FAIL back_to_back pc step %0d: got %0d expected %0d", n, got.pc, p); end
         end
      end
   endtask

   task automatic test_stack_limits();
      obs_t got, exp;
      int   p, n = 0;
      add(ctl(1, 0, 0, 0, 0, 0, '0, '0), 0);
      for (int i = 0; i < 9; i++) add(ctl(0, 0, 1, 0, 0, 0, AW'(100 + i), '0), 100 + i);
      add(ctl(0, 0, 0, 0, 1, 0, '0, '0), 107);
      for (int i = 0; i < 6; i++) add(ctl(0, 0, 0, 1, 0, 0, '0, '0), 106 - i);
      add(ctl(0, 0, 0, 1, 0, 0, '0, '0), 1);
      add(ctl(0, 0, 0, 1, 0, 0, '0, '0), 2);
      while (st_q.size() != 0) begin
         drive_cycle(st_q.pop_front());
         exp = sb_q.pop_front(); got = observe(); p = xp_q.pop_front(); n++;
         checks++;
         if (got !== exp) begin errors++; $display("FAIL stack_limits step %0d: got %p expected %p", n, got, exp); end
         if (p >= 0) begin
            checks++;
            if (got.pc !== AW'(p)) begin errors++; $display("FAIL stack_limits pc step %0d: got %0d expected %0d", n, got.pc, p); end
         end
      end
      checks++;
      if (stk_ovf !== 1'b1 || stk_unf !== 1'b1) begin
         errors++; $display("FAIL stack_flags: got ovf=%b unf=%b expected ovf=1 unf=1", stk_ovf, stk_unf);
      end
   endtask

   task automatic test_reset_mid();
      obs_t got, exp;
      int   p, n = 0;
      add(ctl(1, 0, 0, 0, 0, 0, '0, '0), 0);
      add(ctl(0, 0, 0, 0, 0, 1, '0, 10'd500), 1);
      add(ctl(1, 0, 0, 0, 0, 0, '0, '0), 0);
      add(idle(), 1);
      add(ctl(0, 0, 0, 0, 0, 1, '0, 10'd600), 2);
      add(idle(), 600);
      add(ctl(1, 0, 0, 0, 0, 0, '0, '0), 0);
      add(idle(), 1);
      while (st_q.size() != 0) begin
         drive_cycle(st_q.pop_front());
         exp = sb_q.pop_front(); got = observe(); p = xp_q.pop_front(); n++;
         checks++;
         if (got !== exp) begin errors++; $display("FAIL reset_mid step %0d: got %p expected %p", n, got, exp); end
         if (p >= 0) begin
            checks++;
            if (got.pc !== AW'(p)) begin errors++; $display("FAIL reset_mid pc step %0d: got %0d expected %0d", n, got.pc, p); end
         end
      end
   endtask

`ifdef INTR_MASK_EN
   task automatic test_mask();
      obs_t  got, exp;
      ctrl_t c;
      int    p, n = 0;
      add(ctl(1, 0, 0, 0, 0, 0, '0, '0), 0);
      c = ctl(0, 0, 0, 0, 0, 1, '0, 10'd800); c.ei = 0; add(c, 1);
      c = idle(); c.ei = 0; add(c, 2);
      c = idle(); add(c, 3);
      c = ctl(0, 0, 0, 0, 0, 1, '0, 10'd800); c.ei = 0; add(c, 4);
      c = idle(); c.ei = 0; add(c, 800);
      c = ctl(0, 0, 0, 0, 1, 0, '0, '0); c.ei = 0; add(c, 5);
      c = idle(); c.ei = 0; c.di = 1; add(c, 6);
      c = ctl(0, 0, 0, 0, 0, 1, '0, 10'd900); c.ei = 0; add(c, 7);
      c = idle(); c.ei = 0; add(c, 8);
      while (st_q.size() != 0) begin
         drive_cycle(st_q.pop_front());
         exp = sb_q.pop_front(); got = observe(); p = xp_q.pop_front(); n++;
         checks++;
         if (got !== exp) begin errors++; $display("FAIL mask step %0d: got %p expected %p", n, got, exp); end
         if (p >= 0) begin
            checks++;
            if (got.pc !== AW'(p)) begin errors++; $display("FAIL mask pc step %0d: got %0d expected %0d", n, got.pc, p); end
         end
      end
   endtask
`endif

   task automatic test_random();
      obs_t  got, exp;
      ctrl_t c;
      int    r;
      drive_cycle(ctl(1, 0, 0, 0, 0, 0, '0, '0));
      void'(sb_q.pop_front());
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 15);
         c = idle();
         c.ret  = (r == 0);
         c.reti = (r == 1) || (r == 2);
         c.call = (r == 3) || (r == 5);
         c.jump = (r == 4) || (r == 5);
         c.intr = ($urandom_range(0, 5) == 0);
         c.tgt  = AW'($urandom);
         c.dir  = AW'($urandom);
         c.ei   = ($urandom_range(0, 3) != 0);
         c.di   = ($urandom_range(0, 7) == 0);
         drive_cycle(c);
         exp = sb_q.pop_front(); got = observe();
         checks++;
         if (got !== exp) begin errors++; $display("FAIL random cycle %0d: got %p expected %p", i, got, exp); end
      end
   endtask

   initial begin
      reset = 1'b1; jump = 0; call = 0; ret = 0; reti = 0; s_interrup = 0;
      pc_seq = '0; pc_tgt = '0; dir = '0;
`ifdef INTR_MASK_EN
      ei = 0; di = 0;
`endif
      test_reset();
      test_seq();
      test_call_ret();
      test_interrupt();
      test_defer();
      test_back_to_back();
      test_stack_limits();
      test_reset_mid();
`ifdef INTR_MASK_EN
      test_mask();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
